reg_scan8: RTL



---
 rtl/reg_scan8_pkg.sv | 27 ++
 rtl/reg_scan8_mux.sv | 17 +
 rtl/reg_scan8.sv | 117 +++++++++++
 3 files changed

// File: rtl/reg_scan8_pkg.sv
// Shared definitions for the reg_scan8 register bank and its scan sequencer.
// Latency: none (types, constants and a pure function only).
// Backpressure: not applicable.
package reg_scan8_pkg;

  localparam int WIDTH      = 16;  // word width of the 8-way mux datapath
  localparam int DEPTH      = 8;   // fixed entry count, 3-bit address
  localparam int SCAN_AW    = 3;   // entry address width
  localparam int SCAN_LEN_W = 4;   // scan length field width

  typedef enum logic {
    IDLE = 1'b0,
    SCAN = 1'b1
  } state_t;

  typedef logic [WIDTH-1:0]             word_t;
  typedef logic [DEPTH-1:0][WIDTH-1:0]  bank_t;

  // A length of 0 or anything above the bank depth means "scan the whole bank".
  function automatic logic [SCAN_LEN_W-1:0] clamp_len(input logic [SCAN_LEN_W-1:0] len);
    if (len == '0 || len > SCAN_LEN_W'(DEPTH)) begin
      return SCAN_LEN_W'(DEPTH);
    end
    return len;
  endfunction

endpackage

// File: rtl/reg_scan8_mux.sv
// 8-way word-wide select feeding the scan output register.
// Latency: combinational.
// Backpressure: none; the caller holds sel and ignores the result when stalled.
module reg_scan8_mux
  import reg_scan8_pkg::*;
(
  input  bank_t                in_dat,
  input  logic [SCAN_AW-1:0]   sel,
  output word_t                out_dat
);

  // Pick the addressed word.
  always_comb begin
    out_dat = in_dat[sel];
  end

endmodule

// File: rtl/reg_scan8.sv
// 8x16 register bank with a start/len-controlled read-out scan over valid/ready.
// Latency: first word valid the cycle after start is sampled; one word per cycle with ready high.
// Backpressure: out_data/out_last hold while out_valid && !out_ready, even if the shown entry is rewritten.
module reg_scan8
  import reg_scan8_pkg::*;
(
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   we,
  input  logic [SCAN_AW-1:0]     waddr,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   start,
  input  logic [SCAN_AW-1:0]     start_addr,
  input  logic [SCAN_LEN_W-1:0]  len,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   out_last,
  output logic                   busy,
  output logic                   done
);

  bank_t                  mem_q,       mem_d;
  state_t                 state_q,     state_d;
  logic [SCAN_AW-1:0]     ptr_q,       ptr_d;
  logic [SCAN_LEN_W-1:0]  remain_q,    remain_d;
  word_t                  out_data_q,  out_data_d;
  logic                   out_valid_q, out_valid_d;
  logic                   done_q,      done_d;

  logic [SCAN_AW-1:0]     next_ptr;
  word_t                  mux_dat;
  logic                   xfer;

  // The mux reads the registered bank, so a same-edge write is never seen by the capture (read-old).
  reg_scan8_mux u_mux (
    .in_dat  (mem_q),
    .sel     (next_ptr),
    .out_dat (mux_dat)
  );

  // Register bank write port; writes are accepted in every state.
  always_comb begin
    mem_d = mem_q;
    if (we) begin
      mem_d[waddr] = wdata;
    end
  end

  // Scan sequencer: next-state, pointer/remain stepping and output capture.
  always_comb begin
    xfer        = out_valid_q && out_ready;
    next_ptr    = (state_q == IDLE) ? start_addr : (ptr_q + 3'd1);
    state_d     = state_q;
    ptr_d       = ptr_q;
    remain_d    = remain_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = SCAN;
          ptr_d       = start_addr;
          remain_d    = clamp_len(len);
          out_data_d  = mux_dat;
          out_valid_d = 1'b1;
        end
      end
      SCAN: begin
        if (xfer) begin
          if (remain_q > 4'd1) begin
            ptr_d      = next_ptr;
            remain_d   = remain_q - 4'd1;
            out_data_d = mux_dat;
          end else begin
            state_d     = IDLE;
            remain_d    = '0;
            out_valid_d = 1'b0;
            done_d      = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset clears the bank and aborts any scan.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mem_q       <= '0;
      state_q     <= IDLE;
      ptr_q       <= '0;
      remain_q    <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      remain_q    <= remain_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      done_q      <= done_d;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_valid_q && (remain_q == 4'd1);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

endmodule
